// File: rtl/victim_wb_buffer_if.sv
// Line-transfer bus shared by the victim-cache side and the memory side of the write-back buffer.
// The master drives address/read/write/wdata; the slave answers with rdata and a one-cycle resp.
interface victim_wb_buffer_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              resp;

   modport master (output address, read, write, wdata, input rdata, resp);
   modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/victim_wb_buffer.sv
// Write-back buffer between the victim cache and memory: absorbs evictions, drains them in the
// background and serves line reads from buffered data. Define WB_COALESCE_EN to merge same-line writes.
module victim_wb_buffer #(
   parameter int DEPTH       = 4,
   parameter int LINE_W      = 128,
   parameter int ADDR_W      = 16,
   parameter int OFFSET_BITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   victim_wb_buffer_if.slave  vc,
   victim_wb_buffer_if.master pmem,
   output logic               buf_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = ADDR_W - OFFSET_BITS;

   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_HIT, S_READ, S_RESP, S_DRAIN} state_t;

   state_t            r_state, w_state_next;
   logic [DEPTH-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [LINE_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [LINE_W-1:0] r_vc_rdata;

   logic [TAG_W-1:0]  w_vc_tag;
   logic [DEPTH-1:0]  w_match;
   logic              w_hit;
   logic [PTR_W-1:0]  w_hit_idx;
   logic              w_full, w_coal_ok;
   logic              w_append, w_coalesce, w_pop, w_load_hit;
   logic              w_unused_offset;

   assign w_vc_tag        = vc.address[ADDR_W-1:OFFSET_BITS];
   assign w_unused_offset = ^vc.address[OFFSET_BITS-1:0];
   assign w_full          = (r_count == CNT_W'(DEPTH));

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign w_match[gi] = r_valid[gi] && (r_tag[gi] == w_vc_tag);
      end
   endgenerate

   // Walk from oldest to youngest so the last match seen is the youngest copy.
   always_comb begin : youngest_hit
      logic [PTR_W-1:0] idx;
      w_hit     = 1'b0;
      w_hit_idx = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = r_head + PTR_W'(k);
         if (w_match[idx]) begin
            w_hit     = 1'b1;
            w_hit_idx = idx;
         end
      end
   end

`ifdef WB_COALESCE_EN
   assign w_coal_ok = w_hit && !((r_state == S_DRAIN) && (w_hit_idx == r_head));
`else
   assign w_coal_ok = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_append     = 1'b0;
      w_coalesce   = 1'b0;
      w_pop        = 1'b0;
      w_load_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (vc.read) begin
               if (w_hit) begin
                  w_state_next = S_HIT;
                  w_load_hit   = 1'b1;
               end else begin
                  w_state_next = S_READ;
               end
            end else if (vc.write && (w_coal_ok || !w_full)) begin
               w_coalesce   = w_coal_ok;
               w_append     = !w_coal_ok;
               w_state_next = S_ACCEPT;
            end else if (r_count != '0) begin
               w_state_next = S_DRAIN;
            end
         end
         S_ACCEPT, S_HIT, S_RESP: w_state_next = S_IDLE;
         S_READ: if (pmem.resp) w_state_next = S_RESP;
         S_DRAIN: begin
            // A write stalled behind this drain takes the freed slot in the same cycle.
            if (pmem.resp) begin
               w_pop        = 1'b1;
               w_state_next = S_IDLE;
               if (vc.write && !vc.read) begin
                  w_coalesce   = w_coal_ok;
                  w_append     = !w_coal_ok;
                  w_state_next = S_ACCEPT;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_vc_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_append) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_append) - CNT_W'(w_pop);
         if (w_load_hit)
            r_vc_rdata <= r_data[w_hit_idx];
         else if ((r_state == S_READ) && pmem.resp)
            r_vc_rdata <= pmem.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_append) begin
         r_tag[r_tail]  <= w_vc_tag;
         r_data[r_tail] <= vc.wdata;
      end
      if (w_coalesce)
         r_data[w_hit_idx] <= vc.wdata;
   end

   always_comb begin
      pmem.address = '0;
      pmem.wdata   = '0;
      case (r_state)
         S_DRAIN: begin
            pmem.address = {r_tag[r_head], {OFFSET_BITS{1'b0}}};
            pmem.wdata   = r_data[r_head];
         end
         S_READ:  pmem.address = {w_vc_tag, {OFFSET_BITS{1'b0}}};
         default: ;
      endcase
   end

   assign pmem.read  = (r_state == S_READ);
   assign pmem.write = (r_state == S_DRAIN);
   assign vc.rdata   = r_vc_rdata;
   assign vc.resp    = (r_state == S_ACCEPT) || (r_state == S_HIT) || (r_state == S_RESP);
   assign buf_empty  = (r_count == '0);
endmodule

// File: tb/tb_victim_wb_buffer.sv
// Directed bench for victim_wb_buffer with a latency-controlled memory responder that logs every
// completed memory transfer. Build with +define+WB_COALESCE_EN to cover the coalescing variant.
module tb_victim_wb_buffer;
   localparam int ADDR_W  = 16;
   localparam int LINE_W  = 128;
   localparam int MEM_LAT = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic buf_empty;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   victim_wb_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) vc_if ();
   victim_wb_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) pmem_if ();

   victim_wb_buffer #(.DEPTH(4), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_BITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .vc        (vc_if),
      .pmem      (pmem_if),
      .buf_empty (buf_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Memory responder: completes a held request MEM_LAT cycles after it is seen, unless mem_hold.
   logic              mem_hold = 1'b1;
   logic [ADDR_W-1:0] log_addr [$];
   logic [LINE_W-1:0] log_data [$];
   logic              log_wr   [$];
   int                last_resp_cyc = -1;
   int                wait_cnt = 0;

   initial begin
      pmem_if.resp  = 1'b0;
      pmem_if.rdata = '0;
      forever begin
         @(posedge clk); #1;
         pmem_if.resp = 1'b0;
         if (reset) begin
            wait_cnt = 0;
         end else if ((pmem_if.read || pmem_if.write) && !mem_hold) begin
            if (wait_cnt >= MEM_LAT) begin
               wait_cnt      = 0;
               last_resp_cyc = cyc;
               pmem_if.resp  = 1'b1;
               if (pmem_if.read) pmem_if.rdata = {8{pmem_if.address}};
               log_addr.push_back(pmem_if.address);
               log_wr.push_back(pmem_if.write);
               log_data.push_back(pmem_if.write ? pmem_if.wdata : pmem_if.rdata);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   int   both_cnt = 0;
   int   consec_cnt = 0;
   int   post_rst_act = 0;
   logic prev_resp = 1'b0;
   logic watch_act = 1'b0;

   always @(negedge clk) begin
      if (pmem_if.read && pmem_if.write) both_cnt <= both_cnt + 1;
      if (prev_resp && vc_if.resp) consec_cnt <= consec_cnt + 1;
      if (watch_act && (pmem_if.read || pmem_if.write)) post_rst_act <= post_rst_act + 1;
      prev_resp <= vc_if.resp;
   end

   always @(negedge clk)
      if (!reset) assert (!(vc_if.read && vc_if.write)) else $error("vc read and write asserted together");

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_wr.delete();
   endtask

   task automatic vc_op(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wd,
                        output logic [LINE_W-1:0] rd, output int lat, output int resp_cyc);
      vc_if.address = addr;
      vc_if.wdata   = wd;
      vc_if.read    = !wr;
      vc_if.write   = wr;
      lat      = 0;
      rd       = '0;
      resp_cyc = -1;
      while (lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (vc_if.resp) begin
            rd       = vc_if.rdata;
            resp_cyc = cyc;
            break;
         end
      end
      vc_if.read  = 1'b0;
      vc_if.write = 1'b0;
      check_val("vc_resp_seen", resp_cyc >= 0, 1);
      $display("vc %s addr=%04h lat=%0d rdata=%0h", wr ? "WR" : "RD", addr, lat, rd);
   endtask

   task automatic wait_pmem_write(input string tag);
      int n = 0;
      while (!pmem_if.write && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val(tag, pmem_if.write, 1);
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (!buf_empty && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_val(tag, buf_empty, 1);
   endtask

   logic [LINE_W-1:0] rd, exp_line;
   int                lat, rc, first_resp;

   initial begin
      vc_if.address = '0;
      vc_if.wdata   = '0;
      vc_if.read    = 1'b0;
      vc_if.write   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check_val("rst_vc_resp", vc_if.resp, 0);
      check_val("rst_vc_rdata", vc_if.rdata, 0);
      check_val("rst_pmem_read", pmem_if.read, 0);
      check_val("rst_pmem_write", pmem_if.write, 0);
      check_val("rst_pmem_addr", pmem_if.address, 0);
      check_val("rst_pmem_wdata", pmem_if.wdata, 0);
      check_val("rst_buf_empty", buf_empty, 1);

      // 1: eviction acknowledged next cycle, then drained to memory
      clear_log();
      mem_hold = 1'b1;
      vc_op(1'b1, 16'h1230, {4{32'hD0D0_0000}}, rd, lat, rc);
      check_val("t1_wr_lat", lat, 1);
      wait_pmem_write("t1_drain_start");
      check_val("t1_pmem_addr", pmem_if.address, 16'h1230);
      check_val("t1_pmem_wdata", pmem_if.wdata, {4{32'hD0D0_0000}});
      check_val("t1_pmem_read", pmem_if.read, 0);
      mem_hold = 1'b0;
      wait_empty("t1_empty");
      check_val("t1_log_n", log_addr.size(), 1);
      check_val("t1_log_addr", log_addr[0], 16'h1230);
      check_val("t1_log_data", log_data[0], {4{32'hD0D0_0000}});

      // 2: read hit on a buffered line, offset bits ignored, no memory read
      clear_log();
      mem_hold = 1'b1;
      vc_op(1'b1, 16'h4000, {4{32'hD1D1_0001}}, rd, lat, rc);
      check_val("t2_wr_lat", lat, 1);
      vc_op(1'b0, 16'h4008, '0, rd, lat, rc);
      check_val("t2_rd_lat", lat, 2);
      check_val("t2_rd_data", rd, {4{32'hD1D1_0001}});
      mem_hold = 1'b0;
      wait_empty("t2_empty");
      check_val("t2_log_n", log_addr.size(), 1);
      check_val("t2_no_read", log_wr[0], 1);

      // 3: fill, then a fifth write stalls until the first drain completes
      clear_log();
      mem_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vc_op(1'b1, 16'(16'h1000 + i * 16), {4{32'hA0A0_0000 | 32'(i)}}, rd, lat, rc);
         check_val("t3_fill_lat", lat, (i == 0) ? 1 : 2);
      end
      check_val("t3_full_not_empty", buf_empty, 0);
      fork
         vc_op(1'b1, 16'h1040, {4{32'hA0A0_0004}}, rd, lat, rc);
         begin
            repeat (8) @(posedge clk);
            #1;
            mem_hold = 1'b0;
         end
      join
      first_resp = last_resp_cyc;
      check_val("t3_stalled", lat > 8, 1);
      check_val("t3_resp_after_drain", rc, first_resp + 1);
      wait_empty("t3_empty");
      check_val("t3_log_n", log_addr.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check_val("t3_drain_addr", log_addr[i], 16'(16'h1000 + i * 16));
         check_val("t3_drain_data", log_data[i], {4{32'hA0A0_0000 | 32'(i)}});
      end

      // 4: read miss waits for the in-flight drain, then fetches from memory
      clear_log();
      mem_hold = 1'b1;
      vc_op(1'b1, 16'h3000, {4{32'hB0B0_0000}}, rd, lat, rc);
      wait_pmem_write("t4_drain_start");
      fork
         vc_op(1'b0, 16'h8000, '0, rd, lat, rc);
         begin
            repeat (4) @(posedge clk);
            #1;
            mem_hold = 1'b0;
         end
      join
      exp_line = {8{16'h8000}};
      check_val("t4_rd_data", rd, exp_line);
      check_val("t4_resp_after_pmem", rc, last_resp_cyc + 1);
      check_val("t4_log_n", log_addr.size(), 2);
      check_val("t4_first_is_write", log_wr[0], 1);
      check_val("t4_second_is_read", log_wr[1], 0);
      check_val("t4_read_addr", log_addr[1], 16'h8000);

      // 5: two writes to one line, read returns the younger data
      clear_log();
      mem_hold = 1'b1;
      vc_op(1'b1, 16'h2000, {4{32'hE0E0_0000}}, rd, lat, rc);
      vc_op(1'b1, 16'h2000, {4{32'hE1E1_0001}}, rd, lat, rc);
      check_val("t5_wr2_lat", lat, 2);
      vc_op(1'b0, 16'h2000, '0, rd, lat, rc);
      check_val("t5_rd_data", rd, {4{32'hE1E1_0001}});
      mem_hold = 1'b0;
      wait_empty("t5_empty");
`ifdef WB_COALESCE_EN
      check_val("t5_log_n", log_addr.size(), 1);
      check_val("t5_drain0", log_data[0], {4{32'hE1E1_0001}});
`else
      check_val("t5_log_n", log_addr.size(), 2);
      check_val("t5_drain0", log_data[0], {4{32'hE0E0_0000}});
      check_val("t5_drain1", log_data[1], {4{32'hE1E1_0001}});
`endif

      // 6: reset during a drain discards the buffer and stops memory traffic
      clear_log();
      mem_hold = 1'b1;
      vc_op(1'b1, 16'h5000, {4{32'hF0F0_0000}}, rd, lat, rc);
      wait_pmem_write("t6_drain_start");
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("t6_pmem_write", pmem_if.write, 0);
      check_val("t6_pmem_read", pmem_if.read, 0);
      check_val("t6_buf_empty", buf_empty, 1);
      check_val("t6_vc_resp", vc_if.resp, 0);
      reset     = 1'b0;
      watch_act = 1'b1;
      mem_hold  = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_val("t6_no_activity", post_rst_act, 0);
      check_val("t6_log_n", log_addr.size(), 0);

      check_val("both_rd_wr", both_cnt, 0);
      check_val("resp_back_to_back", consec_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
